// File: rtl/sw_cfg_responder.sv
// Switch-side config responder: captures one select, waits READ_DELAY cycles,
// then accesses the local register bank and returns a one-cycle ack (+ data/err).
module sw_cfg_responder #(
  parameter int W_WIDTH    = 8,
  parameter int NUM_REGS   = 8,
  parameter int READ_DELAY = 1,
  parameter int SW_ID      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel_en_in,
  input  logic                          wr_rd_s_in,
  input  logic [W_WIDTH-1:0]            addr_in,
  input  logic [W_WIDTH-1:0]            wr_data_in,
  output logic                          ack_out,
  output logic [W_WIDTH-1:0]            rd_data_out,
  output logic                          err_out,
  output logic                          busy_out,
  output logic [NUM_REGS*W_WIDTH-1:0]   cfg_regs_out
);

  localparam int                 CNT_W        = (READ_DELAY < 2) ? 1 : $clog2(READ_DELAY + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD     = CNT_W'(READ_DELAY);
  // One extra bit so NUM_REGS == 2^W_WIDTH still compares correctly.
  localparam logic [W_WIDTH:0]   NUM_REGS_EXT = (W_WIDTH + 1)'(NUM_REGS);
  localparam logic [W_WIDTH-1:0] ID_VAL       = W_WIDTH'(SW_ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 capture;
  logic                 do_access;

  logic                 cap_wr;
  logic [W_WIDTH-1:0]   cap_addr;
  logic [W_WIDTH-1:0]   cap_data;

  logic [W_WIDTH-1:0]   regs [NUM_REGS];

  logic                 addr_ok;
  logic                 acc_err;
  logic                 acc_wr_ok;
  logic [W_WIDTH-1:0]   acc_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_en_in) begin
          capture   = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          do_access = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy_out = (state != S_IDLE);

  // Selects arriving outside IDLE never reach these registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_wr   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (capture) begin
      cap_wr   <= wr_rd_s_in;
      cap_addr <= addr_in;
      cap_data <= wr_data_in;
    end
  end

  always_comb begin
    addr_ok   = ({1'b0, cap_addr} < NUM_REGS_EXT);
    acc_wr_ok = cap_wr && addr_ok && (cap_addr != '0);
    acc_err   = !addr_ok || (cap_wr && (cap_addr == '0));
    acc_rd    = '0;
    if (!cap_wr && addr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cap_addr == W_WIDTH'(i)) begin
          acc_rd = regs[i];
        end
      end
    end
  end

  // rd_data_out stays zero outside the ack cycle so per-switch buses can be OR-ed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_out     <= 1'b0;
      err_out     <= 1'b0;
      rd_data_out <= '0;
    end else begin
      ack_out     <= do_access;
      err_out     <= do_access && acc_err;
      rd_data_out <= do_access ? acc_rd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs[0] <= ID_VAL;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[0] <= ID_VAL;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (do_access && acc_wr_ok && (cap_addr == W_WIDTH'(i))) begin
          regs[i] <= cap_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs_out[g*W_WIDTH +: W_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_sw_cfg_responder.sv
// Bench for sw_cfg_responder: three instances (READ_DELAY 1/0/4) checked against
// a per-transaction reference model of the register bank and ack timing.
module tb_sw_cfg_responder;

  localparam int         DLY  [3] = '{1, 0, 4};
  localparam logic [7:0] SWID [3] = '{8'h5A, 8'hC3, 8'h11};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel [3];
  logic        wr_rd;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        ack_o  [3];
  logic        err_o  [3];
  logic        busy_o [3];
  logic [7:0]  rd_o   [3];
  logic [63:0] cfg_o  [3];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mregs [3][8];

  always #5 clk = ~clk;

  sw_cfg_responder #(.W_WIDTH(8), .NUM_REGS(8), .READ_DELAY(1), .SW_ID(8'h5A)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel_en_in(sel[0]), .wr_rd_s_in(wr_rd), .addr_in(addr),
    .wr_data_in(wdata), .ack_out(ack_o[0]), .rd_data_out(rd_o[0]), .err_out(err_o[0]),
    .busy_out(busy_o[0]), .cfg_regs_out(cfg_o[0]));

  sw_cfg_responder #(.W_WIDTH(8), .NUM_REGS(8), .READ_DELAY(0), .SW_ID(8'hC3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel_en_in(sel[1]), .wr_rd_s_in(wr_rd), .addr_in(addr),
    .wr_data_in(wdata), .ack_out(ack_o[1]), .rd_data_out(rd_o[1]), .err_out(err_o[1]),
    .busy_out(busy_o[1]), .cfg_regs_out(cfg_o[1]));

  sw_cfg_responder #(.W_WIDTH(8), .NUM_REGS(8), .READ_DELAY(4), .SW_ID(8'h11)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sel_en_in(sel[2]), .wr_rd_s_in(wr_rd), .addr_in(addr),
    .wr_data_in(wdata), .ack_out(ack_o[2]), .rd_data_out(rd_o[2]), .err_out(err_o[2]),
    .busy_out(busy_o[2]), .cfg_regs_out(cfg_o[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cfg(input int d);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[i*8 +: 8] = (i == 0) ? SWID[d] : mregs[d][i];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        mregs[d][i] = 8'h00;
      end
    end
  endtask

  // Entered and left at a negedge with the target instance idle.
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input bit noise);
    int          dl;
    logic [63:0] oldc;
    logic [63:0] newc;
    logic        exp_err;
    logic [7:0]  exp_rd;
    dl      = DLY[d];
    exp_err = (a >= 8) || (wr && a == 0);
    exp_rd  = (!wr && a < 8) ? ((a == 0) ? SWID[d] : mregs[d][a[2:0]]) : 8'h00;
    oldc    = exp_cfg(d);
    if (wr && a >= 1 && a < 8) mregs[d][a[2:0]] = wd;
    newc    = exp_cfg(d);
    sel[d] = 1'b1;
    wr_rd  = wr;
    addr   = a;
    wdata  = wd;
    for (int c = 0; c <= dl + 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("d%0d c%0d ack", d, c), ack_o[d], (c == dl + 1));
      chk($sformatf("d%0d c%0d err", d, c), err_o[d], (c == dl + 1) && exp_err);
      chk($sformatf("d%0d c%0d rd", d, c), rd_o[d], (c == dl + 1) ? exp_rd : 8'h00);
      chk($sformatf("d%0d c%0d busy", d, c), busy_o[d], (c <= dl + 1));
      chk($sformatf("d%0d c%0d cfg", d, c), cfg_o[d], (c <= dl) ? oldc : newc);
      // Selects while busy must be ignored entirely.
      if (noise && c <= dl + 1 && $urandom_range(0, 1) == 1) begin
        sel[d] = 1'b1;
        wr_rd  = 1'($urandom_range(0, 1));
        addr   = 8'($urandom);
        wdata  = 8'($urandom);
      end else begin
        sel[d] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] hd [10];
    logic [7:0] exp1;
    int         n_ack;
    bit         wr;
    logic [7:0] a;
    int         d;

    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) sel[i] = 1'b1;
    wr_rd = 1'b1;
    addr  = 8'h02;
    wdata = 8'hAA;

    // Reset held two edges with selects asserted.
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst e%0d d%0d ack", e, i), ack_o[i], 1'b0);
        chk($sformatf("rst e%0d d%0d err", e, i), err_o[i], 1'b0);
        chk($sformatf("rst e%0d d%0d busy", e, i), busy_o[i], 1'b0);
        chk($sformatf("rst e%0d d%0d rd", e, i), rd_o[i], 8'h00);
        chk($sformatf("rst e%0d d%0d cfg", e, i), cfg_o[i], exp_cfg(i));
      end
    end
    for (int i = 0; i < 3; i++) sel[i] = 1'b0;
    rst_n = 1'b1;

    // Write then read, errors, delay sweep.
    txn(0, 1'b1, 8'd3, 8'h3C, 1'b0);
    txn(0, 1'b0, 8'd3, 8'h00, 1'b0);
    txn(0, 1'b1, 8'd0, 8'hFF, 1'b0);
    txn(0, 1'b0, 8'd0, 8'h00, 1'b0);
    txn(0, 1'b0, 8'd8, 8'h00, 1'b0);
    txn(0, 1'b1, 8'd255, 8'h12, 1'b0);
    txn(1, 1'b1, 8'd7, 8'h9D, 1'b0);
    txn(1, 1'b0, 8'd7, 8'h00, 1'b0);
    txn(2, 1'b1, 8'd5, 8'h44, 1'b0);
    txn(2, 1'b0, 8'd5, 8'h00, 1'b0);

    // Held select: captures every 4 cycles, each with its own sampled data.
    n_ack = 0;
    exp1  = mregs[0][1];
    for (int i = 0; i < 10; i++) hd[i] = 8'($urandom);
    sel[0] = 1'b1;
    wr_rd  = 1'b1;
    addr   = 8'd1;
    wdata  = hd[0];
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 2)  exp1 = hd[0];
      if (c == 6)  exp1 = hd[4];
      if (c == 10) exp1 = hd[8];
      if (ack_o[0] === 1'b1) n_ack++;
      chk($sformatf("held c%0d ack", c), ack_o[0], (c == 2 || c == 6 || c == 10));
      chk($sformatf("held c%0d busy", c), busy_o[0], (c <= 10) && (c % 4 != 3));
      chk($sformatf("held c%0d err", c), err_o[0], 1'b0);
      chk($sformatf("held c%0d rd", c), rd_o[0], 8'h00);
      chk($sformatf("held c%0d reg1", c), cfg_o[0][15:8], exp1);
      if (c < 9) wdata = hd[c + 1];
      if (c == 9) sel[0] = 1'b0;
    end
    mregs[0][1] = hd[8];
    chk("held ack count", n_ack, 3);

    // Reset while waiting drops the write.
    sel[0] = 1'b1;
    wr_rd  = 1'b1;
    addr   = 8'd2;
    wdata  = 8'h77;
    @(posedge clk);
    @(negedge clk);
    sel[0] = 1'b0;
    chk("midrst busy before", busy_o[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("midrst c%0d ack", c), ack_o[0], 1'b0);
      chk($sformatf("midrst c%0d busy", c), busy_o[0], 1'b0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("midrst c%0d d%0d cfg", c, i), cfg_o[i], exp_cfg(i));
      end
    end
    txn(0, 1'b1, 8'd2, 8'h77, 1'b0);
    txn(0, 1'b0, 8'd2, 8'h00, 1'b0);

    // Randomized traffic with ignored selects while busy.
    for (int n = 0; n < 60; n++) begin
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      txn(d, wr, a, 8'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_cfg_responder.md
# sw_cfg_responder

Switch-side end of the address-decoder-to-switch interface: one instance per switch, driven by one `sel_en` bit plus the shared `addr` / `wr_data` / `wr_rd_s` lines. It accepts one transaction at a time and holds it for a fixed access delay. It then performs the access against a small local configuration register bank and returns a single-cycle `ack`, together with read data, toward the decoder's RX path. Register contents are exported flat to the switch datapath.

## Interface
- `W_WIDTH`, 8: width of address, write data, read data and each register.
- `NUM_REGS`, 8: number of registers; valid addresses are 0..NUM_REGS-1; must be ≥2 and ≤ 2^W_WIDTH.
- `READ_DELAY`, 1: extra wait cycles between capture and access; must be ≥0.
- `SW_ID`, 0: constant returned by read-only register 0.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sel_en_in`  in  1  this switch's select bit from the decoder.
- `wr_rd_s_in`  in  1  1 = write, 0 = read; sampled with `sel_en_in`.
- `addr_in`  in  W_WIDTH  register address; sampled with `sel_en_in`.
- `wr_data_in`  in  W_WIDTH  write data; sampled with `sel_en_in`.
- `ack_out`  out  1  one-cycle completion pulse to the decoder.
- `rd_data_out`  out  W_WIDTH  read data; nonzero only during `ack_out`, so per-switch buses can be OR-combined.
- `err_out`  out  1  one-cycle pulse coincident with `ack_out` for an out-of-range or read-only access.
- `busy_out`  out  1  high whenever state ≠ IDLE.
- `cfg_regs_out`  out  NUM_REGS*W_WIDTH  register bank; register i occupies bits [i*W_WIDTH +: W_WIDTH].

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE**
  - `sel_en_in` = 1 at an edge: capture `addr_in`, `wr_data_in` and `wr_rd_s_in`; load the delay counter with READ_DELAY; go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - Counter ≠ 0: decrement it.
  - Counter = 0: perform the access, set `ack_out` = 1, go to ACK.
- **ACK**
  - Clear `ack_out`, `err_out` and `rd_data_out` to 0; go to IDLE.
- **`sel_en_in` outside IDLE**
  - Ignored. The captured transaction is not modified, and no second ack is produced.
- **Access rules.** The captured address is checked as an unsigned compare against NUM_REGS at full W_WIDTH; it is never truncated.
  - Write, 1 ≤ addr < NUM_REGS: the register is updated on the ack edge.
  - Write to addr 0: register unchanged, `err_out` = 1.
  - Read, addr < NUM_REGS: `rd_data_out` = register value. Register 0 always reads SW_ID.
  - Any access with addr ≥ NUM_REGS: no state change, `rd_data_out` = 0, `err_out` = 1.
  - Write ack: `rd_data_out` = 0.
- **Write visibility.** A write becomes visible on `cfg_regs_out` in the same cycle `ack_out` is high.

## Timing
- **Reset values** (when `rst_n` = 0 at an edge):
  - State IDLE, counter 0.
  - `ack_out`, `err_out`, `busy_out` and `rd_data_out` all 0.
  - Registers 1..NUM_REGS-1 = 0; register 0 = SW_ID.
  - Reset in WAIT or ACK drops the pending transaction; no ack follows.
- **Latency.** With `sel_en_in` sampled at edge k:
  - `busy_out` is high from edge k.
  - `ack_out` is high for exactly the one cycle after edge k+READ_DELAY+1.
  - The FSM is back in IDLE after edge k+READ_DELAY+2.
  - The earliest next capture is at edge k+READ_DELAY+3.
  - READ_DELAY = 0 gives ack at edge k+1.
- **Output types.** `ack_out`, `err_out`, `rd_data_out` and the registers are registered outputs. `busy_out` is decoded from the state register only.
- **Back-to-back selects.** Holding `sel_en_in` high continuously yields one transaction per READ_DELAY+3 cycles. Each transaction uses the values sampled at its own capture edge.

## Test plan
- **Reset.** Assert `rst_n` = 0 for 2 cycles with `sel_en_in` = 1 and SW_ID = 0x5A → all outputs 0; `cfg_regs_out` reg0 = 0x5A, others 0; no ack during reset.
- **Write then read.** Write 0x3C to addr 3 with `sel_en_in` at edge k, READ_DELAY = 1 → ack pulse after edge k+2 only, reg3 = 0x3C, `err_out` = 0. Read addr 3 → `rd_data_out` = 0x3C during ack only, 0 otherwise.
- **Errors.** Write 0xFF to addr 0 → ack with `err_out` = 1, reg0 stays 0x5A. Read addr 8 (NUM_REGS = 8) → ack, `err_out` = 1, `rd_data_out` = 0.
- **Held select.** Hold `sel_en_in` high for 10 cycles with a write to addr 1 (READ_DELAY = 1) → exactly 3 acks, at 4-cycle spacing; `busy_out` low for exactly one cycle between transactions.
- **Reset mid-operation.** Reset in WAIT during a write of 0x77 to addr 2 → no ack, reg2 = 0, FSM in IDLE; the next transaction completes normally.
- **Delay sweep.** Run READ_DELAY = 0 and READ_DELAY = 4 → ack at edge k+1 and k+5 respectively.
